// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the control unit (master)
// and the multicycle signed divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             div_zero;
  logic             busy;

  modport master (
    output start, dividend, divisor,
    input  hi, lo, done, div_zero, busy
  );

  modport slave (
    input  start, dividend, divisor,
    output hi, lo, done, div_zero, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Multicycle signed divider with MIPS DIV semantics: restoring division on
// magnitudes, one quotient bit per clock, then a sign fix-up into lo/hi.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH-1:0] mag_dividend;
  logic [WIDTH-1:0] mag_divisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Since rem < dvsr <= 2^(WIDTH-1), the shifted remainder stays below 2^WIDTH,
  // so a WIDTH+1-bit difference carries a reliable sign bit.
  always_comb begin
    mag_dividend = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    mag_divisor  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    shifted      = {rem, quo[WIDTH-1]};
    diff         = shifted - {1'b0, dvsr};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              dz_q <= 1'b1;
            end else begin
              quo    <= mag_dividend;
              dvsr   <= mag_divisor;
              sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              sign_r <= bus.dividend[WIDTH-1];
              rem    <= '0;
              count  <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          lo_q   <= sign_q ? -quo : quo;
          hi_q   <= sign_r ? -rem : rem;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = (state == CALC) || (state == FIX);
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a latency/arithmetic reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_seq_divider;
  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   edge_cnt     = 0;
  int   last_e0      = 0;

  seq_divider_if #(.WIDTH(WIDTH)) dbus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dbus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: truncating signed division in 64-bit arithmetic, returns {rem, quo}.
  function automatic logic [2*WIDTH-1:0] ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint sa;
    longint sb;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = WIDTH'(sa / sb);
    r  = WIDTH'(sa % sb);
    return {r, q};
  endfunction

  logic [WIDTH-1:0]   m_hi;
  logic [WIDTH-1:0]   m_lo;
  logic [2*WIDTH-1:0] m_pend;
  logic               m_done;
  logic               m_dz;
  int                 m_left;

  // A result lands LATENCY edges after an accepted start; starts are ignored meanwhile.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_done       <= 1'b1;
        end
      end else if (dbus.start) begin
        if (dbus.divisor == '0) begin
          m_dz <= 1'b1;
        end else begin
          m_pend <= ref_div(dbus.dividend, dbus.divisor);
          m_left <= LATENCY;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at t=%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cmp("cyc_hi", dbus.hi, m_hi);
      cmp("cyc_lo", dbus.lo, m_lo);
      cmp("cyc_done", WIDTH'(dbus.done), WIDTH'(m_done));
      cmp("cyc_div_zero", WIDTH'(dbus.div_zero), WIDTH'(m_dz));
      cmp("cyc_busy", WIDTH'(dbus.busy), WIDTH'(m_left != 0));
    end
  end

  // Called at a falling edge; start is sampled on the next rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    dbus.dividend = a;
    dbus.divisor  = b;
    dbus.start    = 1'b1;
    last_e0       = edge_cnt + 1;
    @(negedge clk);
    dbus.start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    cmp({name, "_hi"}, dbus.hi, exp_hi);
    cmp({name, "_lo"}, dbus.lo, exp_lo);
    cmp({name, "_model_hi"}, m_hi, exp_hi);
    cmp({name, "_model_lo"}, m_lo, exp_lo);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!dbus.done && n < LATENCY + 8) begin
      @(negedge clk);
      n++;
    end
    if (!dbus.done) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s_timeout: done not seen within %0d cycles", name, n);
    end else begin
      cmp({name, "_latency"}, WIDTH'(edge_cnt - last_e0), WIDTH'(LATENCY));
    end
  endtask

  task automatic runDiv(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    applyStimulus(a, b);
    waitDone(name);
    checkOutput(name, exp_hi, exp_lo);
  endtask

  initial begin
    int dones;
    dbus.start    = 1'b0;
    dbus.dividend = '0;
    dbus.divisor  = '0;
    reset         = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset", 32'h0, 32'h0);
    cmp("reset_done", WIDTH'(dbus.done), 32'h0);
    cmp("reset_div_zero", WIDTH'(dbus.div_zero), 32'h0);
    cmp("reset_busy", WIDTH'(dbus.busy), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    runDiv("p100_p7", 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
    runDiv("n100_p7", -32'sd100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    runDiv("p100_n7", 32'd100, -32'sd7, 32'h0000_0002, 32'hFFFF_FFF2);
    runDiv("n100_n7", -32'sd100, -32'sd7, 32'hFFFF_FFFE, 32'h0000_000E);
    runDiv("again", 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

    applyStimulus(32'd55, 32'd0);
    cmp("dz_pulse", WIDTH'(dbus.div_zero), 32'h1);
    cmp("dz_busy", WIDTH'(dbus.busy), 32'h0);
    @(negedge clk);
    cmp("dz_clear", WIDTH'(dbus.div_zero), 32'h0);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (dbus.done) dones++;
    end
    cmp("dz_no_done", WIDTH'(dones), 32'h0);
    checkOutput("dz_keep", 32'h0000_0002, 32'h0000_000E);

    runDiv("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    runDiv("zero_num", 32'd0, 32'd5, 32'h0000_0000, 32'h0000_0000);
    runDiv("small", 32'd5, 32'd100, 32'h0000_0005, 32'h0000_0000);
    runDiv("min_p3", 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 32'hD555_5556);

    applyStimulus(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    dbus.dividend = 32'd9;
    dbus.divisor  = 32'd3;
    dbus.start    = 1'b1;
    @(negedge clk);
    dbus.start = 1'b0;
    waitDone("busy_start");
    checkOutput("busy_start", 32'h0000_0002, 32'h0000_000E);
    runDiv("b2b", 32'd9, 32'd3, 32'h0000_0000, 32'h0000_0003);

    applyStimulus(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort", 32'h0, 32'h0);
    cmp("abort_busy", WIDTH'(dbus.busy), 32'h0);
    cmp("abort_done", WIDTH'(dbus.done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (LATENCY + 6) begin
      @(negedge clk);
      if (dbus.done) dones++;
    end
    cmp("abort_no_done", WIDTH'(dones), 32'h0);
    runDiv("after_abort", 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
